// File: rtl/pipelined_instruction_decoder.sv
`default_nettype none
// ============================================================================
// pipelined_instruction_decoder: FIFO-buffered MIPS decode stage, registered output
// Revision: 1.0
// ============================================================================
module pipelined_instruction_decoder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int SIGN_EXT   = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instruction,
  input  logic [ADDR_WIDTH-1:0]        in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   itype,
  output logic [5:0]                   opcode,
  output logic [4:0]                   rs,
  output logic [4:0]                   rt,
  output logic [4:0]                   rd,
  output logic [4:0]                   shamt,
  output logic [5:0]                   funct,
  output logic [4:0]                   dest_reg,
  output logic [DATA_WIDTH-1:0]        imm_ext,
  output logic [ADDR_WIDTH-1:0]        jump_target,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]       fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  localparam logic [1:0] C_T_R   = 2'd0;
  localparam logic [1:0] C_T_I   = 2'd1;
  localparam logic [1:0] C_T_J   = 2'd2;
  localparam logic [1:0] C_T_JAL = 2'd3;

  logic [31:0]           instr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;

  logic                  out_valid_q;
  logic [1:0]            itype_q, itype_d;
  logic [5:0]            opcode_q, opcode_d, funct_q, funct_d;
  logic [4:0]            rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d, dest_q, dest_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [ADDR_WIDTH-1:0] jt_q, jt_d, pc_q;

  logic                  w_accept, w_fire, w_load, w_fifo_nonempty;
  logic                  w_pop, w_bypass, w_push;
  logic [31:0]           w_src_instr;
  logic [ADDR_WIDTH-1:0] w_src_pc, w_pc4;
  logic [15:0]           w_imm16;
  logic [DATA_WIDTH-1:0] w_zext, w_sext;

  assign in_ready        = (count_q < C_FULL);
  assign w_accept        = in_valid && in_ready;
  assign w_fire          = out_valid_q && out_ready;
  assign w_load          = !out_valid_q || w_fire;
  assign w_fifo_nonempty = (count_q != '0);
  assign w_pop           = w_load && w_fifo_nonempty;
  // An accepted input skips the FIFO only when nothing older is waiting.
  assign w_bypass        = w_load && !w_fifo_nonempty && w_accept;
  assign w_push          = w_accept && !w_bypass;

  assign w_src_instr = w_fifo_nonempty ? instr_mem_q[rd_ptr_q] : in_instruction;
  assign w_src_pc    = w_fifo_nonempty ? pc_mem_q[rd_ptr_q]    : in_pc;
  assign w_pc4       = w_src_pc + ADDR_WIDTH'(4);
  assign w_imm16     = w_src_instr[15:0];
  assign w_zext      = {{(DATA_WIDTH-16){1'b0}}, w_imm16};
  assign w_sext      = {{(DATA_WIDTH-16){w_imm16[15]}}, w_imm16};

  always_comb begin
    opcode_d = w_src_instr[31:26];
    itype_d  = C_T_I;
    rs_d     = '0;
    rt_d     = '0;
    rd_d     = '0;
    shamt_d  = '0;
    funct_d  = '0;
    dest_d   = '0;
    imm_d    = '0;
    jt_d     = '0;
    case (opcode_d)
      6'h00: begin
        itype_d = C_T_R;
        rs_d    = w_src_instr[25:21];
        rt_d    = w_src_instr[20:16];
        rd_d    = w_src_instr[15:11];
        shamt_d = w_src_instr[10:6];
        funct_d = w_src_instr[5:0];
        dest_d  = w_src_instr[15:11];
      end
      6'h02, 6'h03: begin
        itype_d    = (opcode_d == 6'h03) ? C_T_JAL : C_T_J;
        dest_d     = (opcode_d == 6'h03) ? 5'd31 : 5'd0;
        jt_d       = w_pc4;
        jt_d[27:0] = {w_src_instr[25:0], 2'b00};
      end
      default: begin
        rs_d   = w_src_instr[25:21];
        rt_d   = w_src_instr[20:16];
        dest_d = w_src_instr[20:16];
        if (opcode_d == 6'h0F)
          imm_d = w_zext << 16;
        else if (opcode_d == 6'h0C || opcode_d == 6'h0D || opcode_d == 6'h0E)
          imm_d = w_zext;
        else
          imm_d = (SIGN_EXT != 0) ? w_sext : w_zext;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)
      count_d = count_q + CW'(1);
    else if (w_pop && !w_push)
      count_d = count_q - CW'(1);
  end

  // Storage needs no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      instr_mem_q[wr_ptr_q] <= in_instruction;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      itype_q     <= '0;
      opcode_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      shamt_q     <= '0;
      funct_q     <= '0;
      dest_q      <= '0;
      imm_q       <= '0;
      jt_q        <= '0;
      pc_q        <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (w_load) begin
        out_valid_q <= w_fifo_nonempty || w_accept;
        if (w_fifo_nonempty || w_accept) begin
          itype_q  <= itype_d;
          opcode_q <= opcode_d;
          rs_q     <= rs_d;
          rt_q     <= rt_d;
          rd_q     <= rd_d;
          shamt_q  <= shamt_d;
          funct_q  <= funct_d;
          dest_q   <= dest_d;
          imm_q    <= imm_d;
          jt_q     <= jt_d;
          pc_q     <= w_src_pc;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign itype       = itype_q;
  assign opcode      = opcode_q;
  assign rs          = rs_q;
  assign rt          = rt_q;
  assign rd          = rd_q;
  assign shamt       = shamt_q;
  assign funct       = funct_q;
  assign dest_reg    = dest_q;
  assign imm_ext     = imm_q;
  assign jump_target = jt_q;
  assign out_pc      = pc_q;
  assign fifo_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_instruction_decoder.sv
`default_nettype none
// ============================================================================
// tb_pipelined_instruction_decoder: vector table, directed sequences and
// randomized traffic against a queue-based reference model.
// ============================================================================
module tb_pipelined_instruction_decoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instruction, in_pc;
  logic [1:0]  itype;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, dest_reg;
  logic [31:0] imm_ext, jump_target, out_pc;
  logic [2:0]  fifo_count;

  pipelined_instruction_decoder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .SIGN_EXT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .itype(itype), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .dest_reg(dest_reg), .imm_ext(imm_ext),
    .jump_target(jump_target), .out_pc(out_pc), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;
  item_t model_q[$];

  typedef struct {
    logic [1:0]  itype;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [4:0]  dst;
    logic [31:0] imm, jt;
  } dec_t;

  typedef struct {
    logic [31:0] instr, pc;
    dec_t        exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, using plain arithmetic.
  function automatic dec_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    int unsigned op, imm16;
    op    = ins >> 26;
    imm16 = ins & 32'hFFFF;
    d = '{itype: 2'd1, rs: 5'd0, rt: 5'd0, rd: 5'd0, shamt: 5'd0, funct: 6'd0,
          dst: 5'd0, imm: 32'd0, jt: 32'd0};
    if (op == 0) begin
      d.itype = 2'd0;
      d.rs    = 5'((ins >> 21) & 31);
      d.rt    = 5'((ins >> 16) & 31);
      d.rd    = 5'((ins >> 11) & 31);
      d.shamt = 5'((ins >> 6) & 31);
      d.funct = 6'(ins & 63);
      d.dst   = d.rd;
    end else if (op == 2 || op == 3) begin
      d.itype = (op == 3) ? 2'd3 : 2'd2;
      d.dst   = (op == 3) ? 5'd31 : 5'd0;
      d.jt    = ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    end else begin
      d.rs  = 5'((ins >> 21) & 31);
      d.rt  = 5'((ins >> 16) & 31);
      d.dst = d.rt;
      if (op == 15)                  d.imm = imm16 << 16;
      else if (op >= 12 && op <= 14) d.imm = imm16;
      else if (imm16 >= 32768)       d.imm = imm16 | 32'hFFFF_0000;
      else                           d.imm = imm16;
    end
    return d;
  endfunction

  function automatic int m_fcount();
    return (model_q.size() > 0) ? model_q.size() - 1 : 0;
  endfunction

  task automatic check_fields(input string tag, input item_t it);
    dec_t d;
    d = ref_dec(it.instr, it.pc);
    chk({tag, ".itype"},  64'(itype),       64'(d.itype));
    chk({tag, ".opcode"}, 64'(opcode),      64'(it.instr >> 26));
    chk({tag, ".rs"},     64'(rs),          64'(d.rs));
    chk({tag, ".rt"},     64'(rt),          64'(d.rt));
    chk({tag, ".rd"},     64'(rd),          64'(d.rd));
    chk({tag, ".shamt"},  64'(shamt),       64'(d.shamt));
    chk({tag, ".funct"},  64'(funct),       64'(d.funct));
    chk({tag, ".dest"},   64'(dest_reg),    64'(d.dst));
    chk({tag, ".imm"},    64'(imm_ext),     64'(d.imm));
    chk({tag, ".jt"},     64'(jump_target), 64'(d.jt));
    chk({tag, ".pc"},     64'(out_pc),      64'(it.pc));
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"},  64'(out_valid),  64'(model_q.size() > 0));
    chk({tag, ".fifo_count"}, 64'(fifo_count), 64'(m_fcount()));
    chk({tag, ".in_ready"},   64'(in_ready),   64'(m_fcount() < DEPTH));
    if (model_q.size() > 0) check_fields(tag, model_q[0]);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic cycle(input string tag, input bit v, input logic [31:0] ins,
                       input logic [31:0] pc, input bit rdy, input bit fl);
    bit acc, fire;
    in_valid       = v;
    in_instruction = ins;
    in_pc          = pc;
    out_ready      = rdy;
    flush          = fl;
    acc  = v && (m_fcount() < DEPTH);
    fire = (model_q.size() > 0) && rdy;
    @(posedge clk);
    if (fl) model_q.delete();
    else begin
      if (fire) void'(model_q.pop_front());
      if (acc)  model_q.push_back('{instr: ins, pc: pc});
    end
    #1;
    check_all(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".fifo_count"}, 64'(fifo_count), 64'd0);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".fields"},
        64'({itype, opcode, rs, rt, rd, shamt, funct, dest_reg} != '0) |
        64'(imm_ext != 0) | 64'(jump_target != 0) | 64'(out_pc != 0), 64'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [12];
    logic [31:0] r;
    ops = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
            6'h23, 6'h2B, 6'h04};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[31:26] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  vec_t vecs [8];

  initial begin
    vecs[0] = '{32'h0022_1820, 32'h0000_0100, '{2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 5'd3, 32'h0, 32'h0}};
    vecs[1] = '{32'h2085_FFFF, 32'h0000_0104, '{2'd1, 5'd4, 5'd5, 5'd0, 5'd0, 6'h00, 5'd5, 32'hFFFF_FFFF, 32'h0}};
    vecs[2] = '{32'h3485_FFFF, 32'h0000_0108, '{2'd1, 5'd4, 5'd5, 5'd0, 5'd0, 6'h00, 5'd5, 32'h0000_FFFF, 32'h0}};
    vecs[3] = '{32'h3C01_1234, 32'h0000_010C, '{2'd1, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 5'd1, 32'h1234_0000, 32'h0}};
    vecs[4] = '{32'h0C10_0000, 32'h0040_0000, '{2'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 5'd31, 32'h0, 32'h0040_0000}};
    vecs[5] = '{32'h0800_0010, 32'hFFFF_FFFC, '{2'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 5'd0, 32'h0, 32'h0000_0040}};
    vecs[6] = '{32'h3085_8000, 32'h0000_0110, '{2'd1, 5'd4, 5'd5, 5'd0, 5'd0, 6'h00, 5'd5, 32'h0000_8000, 32'h0}};
    vecs[7] = '{32'h8C85_8000, 32'h0000_0114, '{2'd1, 5'd4, 5'd5, 5'd0, 5'd0, 6'h00, 5'd5, 32'hFFFF_8000, 32'h0}};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = '0; in_pc = '0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Vector table: each instruction alone into an empty decoder.
    foreach (vecs[i]) begin
      cycle("vec", 1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0);
      chk("vec.valid", 64'(out_valid),   64'd1);
      chk("vec.itype", 64'(itype),       64'(vecs[i].exp.itype));
      chk("vec.rs",    64'(rs),          64'(vecs[i].exp.rs));
      chk("vec.rt",    64'(rt),          64'(vecs[i].exp.rt));
      chk("vec.rd",    64'(rd),          64'(vecs[i].exp.rd));
      chk("vec.funct", 64'(funct),       64'(vecs[i].exp.funct));
      chk("vec.dest",  64'(dest_reg),    64'(vecs[i].exp.dst));
      chk("vec.imm",   64'(imm_ext),     64'(vecs[i].exp.imm));
      chk("vec.jt",    64'(jump_target), 64'(vecs[i].exp.jt));
      cycle("vec.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Backpressure: six pushes with the consumer stalled.
    for (int i = 0; i < 6; i++)
      cycle("bp.fill", 1'b1, rand_instr(), 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
    chk("bp.full_count", 64'(fifo_count), 64'd4);
    chk("bp.full_ready", 64'(in_ready),   64'd0);
    for (int i = 0; i < 5; i++)
      cycle("bp.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Simultaneous push and pop hold the occupancy.
    for (int i = 0; i < 3; i++)
      cycle("pp.fill", 1'b1, rand_instr(), 32'h2000 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle("pp.steady", 1'b1, rand_instr(), 32'h2100 + 32'(i * 4), 1'b1, 1'b0);
      chk("pp.count", 64'(fifo_count), 64'd2);
    end
    for (int i = 0; i < 3; i++)
      cycle("pp.drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with three queued and an input offered in the same cycle.
    for (int i = 0; i < 4; i++)
      cycle("fl.fill", 1'b1, rand_instr(), 32'h3000 + 32'(i * 4), 1'b0, 1'b0);
    cycle("fl.flush", 1'b1, 32'h0022_1820, 32'h3FF0, 1'b1, 1'b1);
    chk("fl.valid", 64'(out_valid),  64'd0);
    chk("fl.count", 64'(fifo_count), 64'd0);
    cycle("fl.after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("fl.after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with the FIFO holding three.
    for (int i = 0; i < 4; i++)
      cycle("rst.fill", 1'b1, rand_instr(), 32'h4000 + 32'(i * 4), 1'b0, 1'b0);
    chk("rst.pre_count", 64'(fifo_count), 64'd3);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_zero_outputs("rst.async");
    model_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cycle("rst.first", 1'b1, 32'h3C01_1234, 32'h0000_0200, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle("rnd", ($urandom_range(0, 9) < 7), rand_instr(), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/pipelined_instruction_decoder.md
Name: pipelined_instruction_decoder

Overview:
- Buffered, registered MIPS instruction decode stage for the pipelined CPU; sits between fetch and register-file/execute.
- Accepts (instruction, pc) pairs over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Decodes each instruction into fully-specified fields: immediate extension, jump-target formation, destination-register selection; unused fields are zeroed, never stale.
- Presents results from a single output register with its own valid/ready handshake; supports a synchronous flush.

Parameters:
- ADDR_WIDTH, 32, width of pc, out_pc and jump_target; must be >= 32.
- DATA_WIDTH, 32, width of imm_ext; must be >= 32.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SIGN_EXT, 1, default extension of I-type immediates: 1 sign-extends, 0 zero-extends.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous discard of all held instructions.
- in_valid  in  1  instruction/pc present.
- in_ready  out  1  decoder can accept; equals (fifo_count < DEPTH).
- in_instruction  in  32  raw instruction word.
- in_pc  in  ADDR_WIDTH  address of the instruction.
- out_valid  out  1  decoded fields valid.
- out_ready  in  1  consumer accepts the output.
- itype  out  2  0=R, 1=I, 2=J, 3=JAL.
- opcode  out  6  instruction bits [31:26].
- rs, rt, rd, shamt  out  5 each  register and shift fields.
- funct  out  6  function field.
- dest_reg  out  5  write-back register.
- imm_ext  out  DATA_WIDTH  extended immediate.
- jump_target  out  ADDR_WIDTH  J/JAL target.
- out_pc  out  ADDR_WIDTH  pc of the presented instruction.
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy; excludes the output register.

Behaviour:
- Reset:
  - While reset_n is low, all outputs are 0 except in_ready=1.
  - FIFO pointers and count are cleared asynchronously.
- Accept and output:
  - Accept occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Output register loads when it is empty or transferring this cycle. Load source is the FIFO head if fifo_count > 0, otherwise a bypassed input accepted that cycle.
  - Latency: an input accepted at edge N with empty FIFO and free output register gives out_valid=1 after edge N.
  - Order is strictly FIFO; no reordering or dropping except on flush.
  - Push and pop may occur in the same cycle; fifo_count is unchanged.
  - Full FIFO: in_ready=0. in_ready depends only on registered state, with no combinational path from out_ready.
  - Stall: while out_valid && !out_ready, every output field holds stable.
- Decode (registered at output load):
  - R-type (opcode 0): rs, rt, rd, shamt, funct from fields. dest_reg=rd; imm_ext=0; jump_target=0.
  - J (0x02) and JAL (0x03): jump_target = {(pc+4)[ADDR_WIDTH-1:28], instr[25:0], 2'b00}. rs, rt, rd, shamt, funct = 0. dest_reg = 31 for JAL, 0 for J.
  - All other opcodes are I-type: rs and rt from fields; rd, shamt, funct = 0; dest_reg = rt.
    - imm_ext uses SIGN_EXT, except ANDI/ORI/XORI (0x0C/0x0D/0x0E), which always zero-extend.
    - LUI (0x0F): imm_ext = imm << 16, zero-filled.
  - pc+4 wraps modulo 2^ADDR_WIDTH.
- Flush:
  - At the edge where flush=1: FIFO is emptied, out_valid=0, fifo_count=0.
  - An input handshaking in the flush cycle is discarded.
  - Flush overrides push and pop.
- Reset mid-operation: all held instructions are lost. First accept after release behaves as from cold reset.

Test Plan:
- Reset: assert reset_n=0 mid-stream with FIFO holding 3 -> out_valid=0, fifo_count=0, in_ready=1, all fields 0 immediately (asynchronous).
- R-type: 0x00221820 into empty decoder -> after 1 edge: out_valid=1, itype=0, rs=1, rt=2, rd=3, funct=0x20, dest_reg=3, imm_ext=0.
- Immediates (SIGN_EXT=1):
  - 0x2085FFFF -> imm_ext=0xFFFFFFFF, dest_reg=5.
  - 0x3485FFFF -> imm_ext=0x0000FFFF.
  - 0x3C011234 -> imm_ext=0x12340000, dest_reg=1.
- JAL: 0x0C100000 at pc 0x00400000 -> itype=3, jump_target=0x00400000, dest_reg=31.
  - Also: J at pc 0xFFFFFFFC -> upper nibble from wrapped pc+4 = 0.
- Backpressure (DEPTH=4, out_ready=0): push 6 back-to-back -> 5 accepted (1 output + 4 FIFO), in_ready=0 with fifo_count=4.
  - Output holds the first instruction stable.
  - Raise out_ready -> five results in order, one per cycle.
  - Simultaneous push/pop keeps fifo_count constant.
- Flush: with 3 queued and in_valid=1 in the flush cycle -> next cycle out_valid=0, fifo_count=0; the flushed-cycle input never appears.
